// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter: shares the single-port data SRAM between the pipeline MEM stage (P)
// and an auxiliary debug/DMA master (A). P has fixed priority. A starvation counter
// guarantees that A makes progress, and A may lock the SRAM for a bounded burst.
module data_sram_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4,
    parameter int BURST_MAX    = 16
) (
    input  logic        clk,
    input  logic        reset,
    // pipeline port
    input  logic        p_req,
    input  logic [3:0]  p_we,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic        p_gnt,
    output logic        p_rvalid,
    output logic [31:0] p_rdata,
    // auxiliary port
    input  logic        a_req,
    input  logic [3:0]  a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    input  logic        a_last,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    // SRAM side
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_MAX);

    typedef enum logic {
        ST_ARB,
        ST_AUX_BURST
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_P,
        OWN_A
    } owner_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    owner_e              rd_owner_q, rd_owner_d;
    logic                force_a;

    // State register: arbitration state, counters and owner of the in-flight read.
    // NOTE: reset is synchronous here, so it is sampled on clk and kept out of the event list.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ARB;
            starve_cnt_q <= '0;
            beat_cnt_q   <= '0;
            rd_owner_q   <= OWN_NONE;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // Next-state logic: burst lock tracking, starvation counting, read-return owner.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        rd_owner_d   = OWN_NONE;

        if (p_gnt && (p_we == 4'b0000)) begin
            rd_owner_d = OWN_P;
        end else if (a_gnt && (a_we == 4'b0000)) begin
            rd_owner_d = OWN_A;
        end

        case (state_q)
            ST_ARB: begin
                if (a_gnt || !a_req) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q < STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
                // A one-beat limit means every beat is the last one; no lock is taken.
                if (a_gnt && !a_last && (BURST_MAX > 1)) begin
                    state_d    = ST_AUX_BURST;
                    beat_cnt_d = BEAT_W'(1);
                end
            end
            ST_AUX_BURST: begin
                starve_cnt_d = '0;
                if (a_gnt) begin
                    if (a_last || (beat_cnt_q + 1'b1 == BEAT_LAST)) begin
                        state_d    = ST_ARB;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_ARB;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Output logic: grants, SRAM request mux and read-return steering.
    always_comb begin
        p_gnt   = 1'b0;
        a_gnt   = 1'b0;
        force_a = a_req && (starve_cnt_q >= STARVE_MAX);

        // Grants are suppressed while reset is held so nothing reaches the SRAM.
        if (!reset) begin
            case (state_q)
                ST_ARB: begin
                    if (force_a) begin
                        a_gnt = 1'b1;
                    end else if (p_req) begin
                        p_gnt = 1'b1;
                    end else if (a_req) begin
                        a_gnt = 1'b1;
                    end
                end
                ST_AUX_BURST: a_gnt = a_req;
                default: ;
            endcase
        end

        sram_en    = p_gnt | a_gnt;
        sram_we    = 4'b0000;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (p_gnt) begin
            sram_we    = p_we;
            sram_addr  = p_addr;
            sram_wdata = p_wdata;
        end else if (a_gnt) begin
            sram_we    = a_we;
            sram_addr  = a_addr;
            sram_wdata = a_wdata;
        end

        p_rvalid = !reset && (rd_owner_q == OWN_P);
        a_rvalid = !reset && (rd_owner_q == OWN_A);
        p_rdata  = sram_rdata;
        a_rdata  = sram_rdata;
    end

endmodule

// File: tb/tb_data_sram_arbiter.sv
// tb_data_sram_arbiter: table-driven bench for data_sram_arbiter with a behavioural SRAM
// and a per-cycle read-response scoreboard.
module tb_data_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_req = 1'b0, a_req = 1'b0, a_last = 1'b0;
    logic [3:0]  p_we = '0, a_we = '0;
    logic [31:0] p_addr = '0, p_wdata = '0, a_addr = '0, a_wdata = '0;
    logic        p_gnt, p_rvalid, a_gnt, a_rvalid, sram_en;
    logic [31:0] p_rdata, a_rdata, sram_addr, sram_wdata;
    logic [3:0]  sram_we;
    logic [31:0] sram_rdata = '0;

    data_sram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .p_req      (p_req),
        .p_we       (p_we),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_gnt      (p_gnt),
        .p_rvalid   (p_rvalid),
        .p_rdata    (p_rdata),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_addr     (a_addr),
        .a_wdata    (a_wdata),
        .a_last     (a_last),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural SRAM ----------------
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_en && sram_we == 4'b0000) sram_rdata <= mem_rd(sram_addr);
        else                               sram_rdata <= 32'hBAD0_BAD0;
        if (sram_en && sram_we != 4'b0000)
            mem_model[sram_addr] = merge(mem_rd(sram_addr), sram_wdata, sram_we);
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // owner: 0 = no response, 1 = P, 2 = A
    typedef struct {
        int          owner;
        logic [31:0] data;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        string       name;
        logic        rst;
        logic        pr;
        logic [3:0]  pwe;
        logic [31:0] pa;
        logic [31:0] pd;
        logic        ar;
        logic [3:0]  awe;
        logic [31:0] aa;
        logic [31:0] ad;
        logic        al;
        logic        epg;
        logic        eag;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(input string name, input logic rst,
                                input logic pr, input logic [3:0] pwe, input logic [31:0] pa,
                                input logic [31:0] pd, input logic ar, input logic [3:0] awe,
                                input logic [31:0] aa, input logic [31:0] ad, input logic al,
                                input logic epg, input logic eag);
        vec_t v;
        v.name = name; v.rst = rst; v.pr = pr; v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.ar = ar; v.awe = awe; v.aa = aa; v.ad = ad; v.al = al; v.epg = epg; v.eag = eag;
        return v;
    endfunction

    function automatic vec_t rst_v(input string name);
        return mk(name, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check_resp(input string name);
        resp_t r;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got empty scoreboard expected one entry", name);
            return;
        end
        r = sb.pop_front();
        check({name, "_p_rvalid"}, {31'b0, p_rvalid}, {31'b0, r.owner == 1});
        check({name, "_a_rvalid"}, {31'b0, a_rvalid}, {31'b0, r.owner == 2});
        if (r.owner == 1) check({name, "_p_rdata"}, p_rdata, r.data);
        if (r.owner == 2) check({name, "_a_rdata"}, a_rdata, r.data);
    endtask

    // One clock cycle: drive after the edge, check mid-cycle, queue the next-cycle response.
    task automatic apply(input vec_t v);
        logic [3:0]  ewe;
        logic [31:0] ea, ed;
        resp_t       r;
        @(posedge clk);
        #1;
        reset = v.rst;
        p_req = v.pr; p_we = v.pwe; p_addr = v.pa; p_wdata = v.pd;
        a_req = v.ar; a_we = v.awe; a_addr = v.aa; a_wdata = v.ad; a_last = v.al;
        #4;
        if (v.rst) begin
            check({v.name, "_p_gnt"},    {31'b0, p_gnt},    32'h0);
            check({v.name, "_a_gnt"},    {31'b0, a_gnt},    32'h0);
            check({v.name, "_sram_en"},  {31'b0, sram_en},  32'h0);
            check({v.name, "_p_rvalid"}, {31'b0, p_rvalid}, 32'h0);
            check({v.name, "_a_rvalid"}, {31'b0, a_rvalid}, 32'h0);
            sb.delete();
            r.owner = 0; r.data = '0;
            sb.push_back(r);
            return;
        end
        ewe = v.epg ? v.pwe : (v.eag ? v.awe : 4'b0);
        ea  = v.epg ? v.pa  : (v.eag ? v.aa  : 32'h0);
        ed  = v.epg ? v.pd  : (v.eag ? v.ad  : 32'h0);
        check({v.name, "_p_gnt"},      {31'b0, p_gnt},   {31'b0, v.epg});
        check({v.name, "_a_gnt"},      {31'b0, a_gnt},   {31'b0, v.eag});
        check({v.name, "_sram_en"},    {31'b0, sram_en}, {31'b0, v.epg | v.eag});
        check({v.name, "_sram_we"},    {28'b0, sram_we}, {28'b0, ewe});
        check({v.name, "_sram_addr"},  sram_addr,        ea);
        check({v.name, "_sram_wdata"}, sram_wdata,       ed);
        check_resp(v.name);
        r.owner = 0; r.data = '0;
        if (v.epg && v.pwe == 4'b0)      begin r.owner = 1; r.data = mem_rd(v.pa); end
        else if (v.eag && v.awe == 4'b0) begin r.owner = 2; r.data = mem_rd(v.aa); end
        sb.push_back(r);
    endtask

    initial begin
        mem_model[32'h10] = 32'hDEAD_BEEF;

        // 1: single P read after reset
        tbl.push_back(rst_v("t1_rst"));
        tbl.push_back(mk("t1_p_read", 0, 1, 4'h0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t1_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // uncontended alternation P/A reads: owner changes each cycle
        tbl.push_back(rst_v("t5a_rst"));
        tbl.push_back(mk("t5a_p0", 0, 1, 0, 32'h40, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t5a_a0", 0, 0, 0, 0, 0, 1, 0, 32'h44, 0, 1, 0, 1));
        tbl.push_back(mk("t5a_p1", 0, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t5a_a1", 0, 0, 0, 0, 0, 1, 0, 32'h4C, 0, 1, 0, 1));
        tbl.push_back(mk("t5a_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 3: four-beat A burst with an idle gap; P held off until after the last beat
        tbl.push_back(rst_v("t3_rst"));
        tbl.push_back(mk("t3_b1",   0, 0, 0, 0, 0, 1, 4'hF, 32'h80, 32'h1111_0001, 0, 0, 1));
        tbl.push_back(mk("t3_b2",   0, 1, 0, 32'h90, 0, 1, 4'hF, 32'h84, 32'h2222_0002, 0, 0, 1));
        tbl.push_back(mk("t3_gap",  0, 1, 0, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t3_b3",   0, 1, 0, 32'h90, 0, 1, 4'h0, 32'h80, 0, 0, 0, 1));
        tbl.push_back(mk("t3_b4",   0, 1, 0, 32'h90, 0, 1, 4'hF, 32'h88, 32'h4444_0004, 1, 0, 1));
        tbl.push_back(mk("t3_p",    0, 1, 0, 32'h90, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t3_end",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 4: endless A burst released after BURST_MAX beats
        tbl.push_back(rst_v("t4_rst"));
        tbl.push_back(mk("t4_b1", 0, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0, 0, 1));
        for (int i = 2; i <= 16; i++)
            tbl.push_back(mk($sformatf("t4_b%0d", i), 0, 1, 0, 32'hA0, 0, 1, 0,
                             32'h100 + 32'(i * 4), 0, 0, 0, 1));
        tbl.push_back(mk("t4_release", 0, 1, 0, 32'hA0, 0, 1, 0, 32'h200, 0, 0, 1, 0));
        tbl.push_back(mk("t4_end",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 6: reset in beat 3 of a burst with a read pending, then a partial store
        tbl.push_back(rst_v("t6_rst0"));
        tbl.push_back(mk("t6_b1", 0, 0, 0, 0, 0, 1, 4'hF, 32'h300, 32'hCAFE_0001, 0, 0, 1));
        tbl.push_back(mk("t6_b2", 0, 1, 0, 32'h20, 0, 1, 4'hF, 32'h304, 32'hCAFE_0002, 0, 0, 1));
        tbl.push_back(mk("t6_b3", 0, 1, 0, 32'h20, 0, 1, 4'h0, 32'h300, 0, 0, 0, 1));
        tbl.push_back(mk("t6_rst", 1, 1, 0, 32'h20, 0, 1, 0, 32'h308, 0, 0, 0, 0));
        tbl.push_back(mk("t6_store", 0, 1, 4'b0011, 32'h20, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t6_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("t6_read",  0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk("t6_end",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // Partial store must have merged into the reset-default word at 0x20.
        check("t6_merged_word", mem_rd(32'h20), 32'hA585_5678);

        // 2: P continuously requesting, single-beat A forced in on the 9th cycle
        apply(rst_v("t2_rst"));
        for (int i = 0; i < 8; i++)
            apply(mk($sformatf("t2_deny%0d", i), 0, 1, 0, 32'h400 + 32'(i * 4), 0,
                     1, 0, 32'h500, 0, 1, 1, 0));
        apply(mk("t2_force", 0, 1, 0, 32'h420, 0, 1, 0, 32'h500, 0, 1, 0, 1));
        apply(mk("t2_p_back", 0, 1, 0, 32'h420, 0, 1, 0, 32'h504, 0, 1, 1, 0));

        // 5: back-to-back reads where A wins only through forced grants
        apply(rst_v("t5_rst"));
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                apply(mk($sformatf("t5_r%0d_p%0d", r, i), 0, 1, 0, 32'h600 + 32'(r * 64 + i * 4),
                         0, 1, 0, 32'h700 + 32'(r * 4), 0, 1, 1, 0));
            apply(mk($sformatf("t5_r%0d_a", r), 0, 1, 0, 32'h640 + 32'(r * 64), 0,
                     1, 0, 32'h700 + 32'(r * 4), 0, 1, 0, 1));
        end
        apply(mk("t5_p_after", 0, 1, 0, 32'h640 + 32'd64, 0, 0, 0, 0, 0, 0, 1, 0));
        apply(mk("t5_end",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
